// File: rtl/dct_ctrl_pkg.sv
// Shared types for the DCT row sequencer: bank states, default widths and
// pointer types used by the controller, its transpose banks and its interface.
package dct_ctrl_pkg;

  localparam int IW_DEF = 8;
  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  typedef logic       bank_idx_t;
  typedef logic [1:0] rc_cnt_t;

  localparam bank_idx_t BANK_A   = 1'b0;
  localparam bank_idx_t BANK_B   = 1'b1;
  localparam rc_cnt_t   CNT_LAST = 2'd3;

  // A bank can take new rows until its last row has been captured.
  function automatic logic bank_accepts(input bank_state_e st);
    return (st == BANK_EMPTY) || (st == BANK_FILLING);
  endfunction

endpackage

// File: rtl/dct4_block_seq_if.sv
// Row-in / column-out stream bundle of the DCT sequencer. The master side
// drives rows and accepts columns; the slave side is the sequencer.
interface dct4_block_seq_if #(
  parameter int IW = dct_ctrl_pkg::IW_DEF,
  parameter int CW = dct_ctrl_pkg::CW_DEF
) ();

  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_x0;
  logic [IW-1:0] in_x1;
  logic [IW-1:0] in_x2;
  logic [IW-1:0] in_x3;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_c0;
  logic [CW-1:0] out_c1;
  logic [CW-1:0] out_c2;
  logic [CW-1:0] out_c3;
  logic          out_last;

  modport master (
    output in_valid, in_x0, in_x1, in_x2, in_x3, out_ready,
    input  in_ready, out_valid, out_c0, out_c1, out_c2, out_c3, out_last
  );

  modport slave (
    input  in_valid, in_x0, in_x1, in_x2, in_x3, out_ready,
    output in_ready, out_valid, out_c0, out_c1, out_c2, out_c3, out_last
  );

endinterface

// File: rtl/dct_tbuf_bank.sv
// One 4x4 transpose bank: a full row is written per cycle, a full column is
// read combinationally. Contents are deliberately not reset.
module dct_tbuf_bank
  import dct_ctrl_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          i_we,
  input  rc_cnt_t       i_row,
  input  logic [CW-1:0] i_d0,
  input  logic [CW-1:0] i_d1,
  input  logic [CW-1:0] i_d2,
  input  logic [CW-1:0] i_d3,
  input  rc_cnt_t       i_col,
  output logic [CW-1:0] o_q0,
  output logic [CW-1:0] o_q1,
  output logic [CW-1:0] o_q2,
  output logic [CW-1:0] o_q3
);

  logic [CW-1:0] r_mem [4][4];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_row][2'd0] <= i_d0;
      r_mem[i_row][2'd1] <= i_d1;
      r_mem[i_row][2'd2] <= i_d2;
      r_mem[i_row][2'd3] <= i_d3;
    end
  end

  // Column k of the bank: element r comes from row r.
  always_comb begin
    o_q0 = r_mem[2'd0][i_col];
    o_q1 = r_mem[2'd1][i_col];
    o_q2 = r_mem[2'd2][i_col];
    o_q3 = r_mem[2'd3][i_col];
  end

endmodule

// File: rtl/dct4_block_seq.sv
// Row-pass sequencer for the external 4-point DCT core: feeds rows to the core,
// captures coefficients into ping-pong banks and drains them column-major.
module dct4_block_seq
  import dct_ctrl_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dct4_block_seq_if.slave      bus,
  output logic [IW-1:0]        dct_x0,
  output logic [IW-1:0]        dct_x1,
  output logic [IW-1:0]        dct_x2,
  output logic [IW-1:0]        dct_x3,
  input  logic [CW-1:0]        dct_y0,
  input  logic [CW-1:0]        dct_y1,
  input  logic [CW-1:0]        dct_y2,
  input  logic [CW-1:0]        dct_y3,
  output logic [15:0]          blk_cnt,
  output logic                 busy
);

  bank_state_e   r_state_a;
  bank_state_e   r_state_b;
  bank_state_e   w_state_a_nxt;
  bank_state_e   w_state_b_nxt;
  bank_state_e   w_wb_state;
  bank_state_e   w_rb_state;
  bank_idx_t     r_wb;
  bank_idx_t     r_rb;
  rc_cnt_t       r_wr;
  rc_cnt_t       r_rc;
  logic          r_s_vld;
  bank_idx_t     r_s_bank;
  rc_cnt_t       r_s_row;
  logic [IW-1:0] r_dct_x0;
  logic [IW-1:0] r_dct_x1;
  logic [IW-1:0] r_dct_x2;
  logic [IW-1:0] r_dct_x3;
  logic [15:0]   r_blk_cnt;

  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_out_last;
  logic          w_busy;
  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_cap_full;
  logic          w_blk_done;
  logic          w_we_a;
  logic          w_we_b;
  logic [CW-1:0] w_out_c0;
  logic [CW-1:0] w_out_c1;
  logic [CW-1:0] w_out_c2;
  logic [CW-1:0] w_out_c3;
  logic [CW-1:0] w_qa0, w_qa1, w_qa2, w_qa3;
  logic [CW-1:0] w_qb0, w_qb1, w_qb2, w_qb3;

  // A bank only advances one step per event; fill, capture and drain of the
  // same bank can never coincide because they require different states.
  function automatic bank_state_e bank_next(input bank_state_e st, input logic fill,
                                            input logic full, input logic drain);
    bank_state_e nx;
    case (st)
      BANK_EMPTY:   nx = fill  ? BANK_FILLING : BANK_EMPTY;
      BANK_FILLING: nx = full  ? BANK_FULL    : BANK_FILLING;
      BANK_FULL:    nx = drain ? BANK_EMPTY   : BANK_FULL;
      default:      nx = BANK_EMPTY;
    endcase
    return nx;
  endfunction

  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_out_fire = w_out_valid & bus.out_ready;
  assign w_cap_full = r_s_vld & (r_s_row == CNT_LAST);
  assign w_blk_done = w_out_fire & (r_rc == CNT_LAST);
  assign w_we_a     = r_s_vld & (r_s_bank == BANK_A);
  assign w_we_b     = r_s_vld & (r_s_bank == BANK_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_a <= BANK_EMPTY;
      r_state_b <= BANK_EMPTY;
    end else begin
      r_state_a <= w_state_a_nxt;
      r_state_b <= w_state_b_nxt;
    end
  end

  always_comb begin
    w_state_a_nxt = bank_next(r_state_a, w_in_fire & (r_wb == BANK_A),
                              w_cap_full & (r_s_bank == BANK_A),
                              w_blk_done & (r_rb == BANK_A));
    w_state_b_nxt = bank_next(r_state_b, w_in_fire & (r_wb == BANK_B),
                              w_cap_full & (r_s_bank == BANK_B),
                              w_blk_done & (r_rb == BANK_B));
  end

  // Handshakes depend only on registered bank state, never on out_ready.
  always_comb begin
    w_wb_state  = (r_wb == BANK_A) ? r_state_a : r_state_b;
    w_rb_state  = (r_rb == BANK_A) ? r_state_a : r_state_b;
    w_in_ready  = bank_accepts(w_wb_state);
    w_out_valid = (w_rb_state == BANK_FULL);
    w_out_last  = w_out_valid & (r_rc == CNT_LAST);
    w_busy      = (r_state_a != BANK_EMPTY) | (r_state_b != BANK_EMPTY) | r_s_vld;
    if (!w_out_valid) begin
      w_out_c0 = {CW{1'b0}};
      w_out_c1 = {CW{1'b0}};
      w_out_c2 = {CW{1'b0}};
      w_out_c3 = {CW{1'b0}};
    end else if (r_rb == BANK_A) begin
      w_out_c0 = w_qa0;
      w_out_c1 = w_qa1;
      w_out_c2 = w_qa2;
      w_out_c3 = w_qa3;
    end else begin
      w_out_c0 = w_qb0;
      w_out_c1 = w_qb1;
      w_out_c2 = w_qb2;
      w_out_c3 = w_qb3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb      <= BANK_A;
      r_rb      <= BANK_A;
      r_wr      <= 2'd0;
      r_rc      <= 2'd0;
      r_s_vld   <= 1'b0;
      r_s_bank  <= BANK_A;
      r_s_row   <= 2'd0;
      r_dct_x0  <= {IW{1'b0}};
      r_dct_x1  <= {IW{1'b0}};
      r_dct_x2  <= {IW{1'b0}};
      r_dct_x3  <= {IW{1'b0}};
      r_blk_cnt <= 16'd0;
    end else begin
      r_s_vld <= w_in_fire;
      if (w_in_fire) begin
        r_dct_x0 <= bus.in_x0;
        r_dct_x1 <= bus.in_x1;
        r_dct_x2 <= bus.in_x2;
        r_dct_x3 <= bus.in_x3;
        r_s_bank <= r_wb;
        r_s_row  <= r_wr;
        r_wr     <= r_wr + 2'd1;
        if (r_wr == CNT_LAST) begin
          r_wb <= ~r_wb;
        end
      end
      if (w_out_fire) begin
        r_rc <= r_rc + 2'd1;
        if (r_rc == CNT_LAST) begin
          r_rb      <= ~r_rb;
          r_blk_cnt <= r_blk_cnt + 16'd1;
        end
      end
    end
  end

  dct_tbuf_bank #(.CW(CW)) u_bank_a (
    .clk   (clk),
    .i_we  (w_we_a),
    .i_row (r_s_row),
    .i_d0  (dct_y0),
    .i_d1  (dct_y1),
    .i_d2  (dct_y2),
    .i_d3  (dct_y3),
    .i_col (r_rc),
    .o_q0  (w_qa0),
    .o_q1  (w_qa1),
    .o_q2  (w_qa2),
    .o_q3  (w_qa3)
  );

  dct_tbuf_bank #(.CW(CW)) u_bank_b (
    .clk   (clk),
    .i_we  (w_we_b),
    .i_row (r_s_row),
    .i_d0  (dct_y0),
    .i_d1  (dct_y1),
    .i_d2  (dct_y2),
    .i_d3  (dct_y3),
    .i_col (r_rc),
    .o_q0  (w_qb0),
    .o_q1  (w_qb1),
    .o_q2  (w_qb2),
    .o_q3  (w_qb3)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_last  = w_out_last;
  assign bus.out_c0    = w_out_c0;
  assign bus.out_c1    = w_out_c1;
  assign bus.out_c2    = w_out_c2;
  assign bus.out_c3    = w_out_c3;
  assign dct_x0        = r_dct_x0;
  assign dct_x1        = r_dct_x1;
  assign dct_x2        = r_dct_x2;
  assign dct_x3        = r_dct_x3;
  assign blk_cnt       = r_blk_cnt;
  assign busy          = w_busy;

endmodule

// File: tb/tb_dct4_block_seq.sv
// Bench for dct4_block_seq: block-level model (rows in, transposed coefficient
// columns out) checked every cycle, plus directed latency and corner checks.
module tb_dct4_block_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  dct_x0, dct_x1, dct_x2, dct_x3;
  logic [15:0] dct_y0, dct_y1, dct_y2, dct_y3;
  logic [15:0] blk_cnt;
  logic        busy;
  logic [63:0] core_y;

  int          n_vec = 0;
  int          n_err = 0;
  int          e_cnt = 0;
  logic [31:0] part [$];
  logic [64:0] exp_q [$];
  logic [15:0] mdl_blk = 16'd0;
  logic        first_flag = 1'b0;
  int          t_first = 0;
  int          t_last = 0;
  logic [64:0] first_beat = '0;
  logic [64:0] last_beat = '0;

  dct4_block_seq_if #(.IW(8), .CW(16)) bus ();

  dct4_block_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .dct_x0  (dct_x0),
    .dct_x1  (dct_x1),
    .dct_x2  (dct_x2),
    .dct_x3  (dct_x3),
    .dct_y0  (dct_y0),
    .dct_y1  (dct_y1),
    .dct_y2  (dct_y2),
    .dct_y3  (dct_y3),
    .blk_cnt (blk_cnt),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) e_cnt <= e_cnt + 1;

  // Reference core: sum/difference butterfly, y1/y3 with the 2x weight.
  function automatic logic [63:0] core_f(input logic [31:0] row);
    int x0, x1, x2, x3, s0, s1, d0, d1;
    logic [15:0] y0, y1, y2, y3;
    x0 = int'(row[7:0]);   x1 = int'(row[15:8]);
    x2 = int'(row[23:16]); x3 = int'(row[31:24]);
    s0 = x0 + x3; s1 = x1 + x2; d0 = x0 - x3; d1 = x1 - x2;
    y0 = 16'(s0 + s1);
    y1 = 16'(2 * d0 + d1);
    y2 = 16'(s0 - s1);
    y3 = 16'(d0 - 2 * d1);
    return {y3, y2, y1, y0};
  endfunction

  assign core_y = core_f({dct_x3, dct_x2, dct_x1, dct_x0});
  assign dct_y0 = core_y[15:0];
  assign dct_y1 = core_y[31:16];
  assign dct_y2 = core_y[47:32];
  assign dct_y3 = core_y[63:48];

  function automatic logic [31:0] mk_row(input int b, input int r);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = 8'((b * 53 + r * 29 + i * 71 + 7) & 255);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Per-cycle compare against the block model; fires happen at the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [64:0] act;
      logic [64:0] e;
      logic [63:0] yy [4];
      act = {bus.out_last, bus.out_c3, bus.out_c2, bus.out_c1, bus.out_c0};
      chk("blk_cnt", {49'd0, blk_cnt}, {49'd0, mdl_blk});
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", {64'd0, bus.out_valid}, 65'd0);
        end else begin
          chk("col_beat", act, exp_q[0]);
          if (bus.out_ready) begin
            e = exp_q.pop_front();
            if (first_flag) begin
              first_beat = e;
              t_first = e_cnt + 1;
              first_flag = 1'b0;
            end
            if (e[64]) begin
              mdl_blk = mdl_blk + 16'd1;
              last_beat = e;
              t_last = e_cnt + 1;
            end
          end
        end
      end else begin
        chk("idle_zero", act, 65'd0);
      end
      if (bus.in_valid && bus.in_ready) begin
        part.push_back({bus.in_x3, bus.in_x2, bus.in_x1, bus.in_x0});
        if (part.size() == 4) begin
          for (int r = 0; r < 4; r++) yy[r] = core_f(part[r]);
          for (int k = 0; k < 4; k++)
            exp_q.push_back({(k == 3), yy[3][16*k +: 16], yy[2][16*k +: 16],
                             yy[1][16*k +: 16], yy[0][16*k +: 16]});
          part.delete();
        end
      end
    end
  end

  task automatic send_row(input logic [31:0] row, output int fe);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_x0 = row[7:0];   bus.in_x1 = row[15:8];
    bus.in_x2 = row[23:16]; bus.in_x3 = row[31:24];
    @(negedge clk);
    while (!bus.in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("in_ready_timeout", {64'd0, bus.in_ready}, 65'd1);
    @(posedge clk);
    #1;
    fe = e_cnt;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || part.size() != 0) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 500) chk("drain_timeout", 65'(exp_q.size()), 65'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic flush_model();
    part.delete();
    exp_q.delete();
    mdl_blk = 16'd0;
    first_flag = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_valid"}, {64'd0, bus.out_valid}, 65'd0);
    chk({nm, "_cols"}, {bus.out_last, bus.out_c3, bus.out_c2, bus.out_c1, bus.out_c0}, 65'd0);
    chk({nm, "_blk"}, {49'd0, blk_cnt}, 65'd0);
    chk({nm, "_busy"}, {64'd0, busy}, 65'd0);
    chk({nm, "_dctx"}, {33'd0, dct_x3, dct_x2, dct_x1, dct_x0}, 65'd0);
  endtask

  initial begin
    int fe0;
    int fe;
    bus.in_valid = 1'b0;
    bus.in_x0 = 8'd0; bus.in_x1 = 8'd0; bus.in_x2 = 8'd0; bus.in_x3 = 8'd0;
    bus.out_ready = 1'b1;

    // Reset held with inputs toggling.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = ~bus.in_valid;
      bus.in_x0 = 8'(i * 17 + 3);
      bus.out_ready = ~bus.out_ready;
      @(negedge clk);
      check_reset_outputs("rst_hold");
    end
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {64'd0, bus.in_ready}, 65'd1);

    // Single block of rows {1,2,3,4}: columns are constant y_k.
    chk("core_ref", {1'b0, core_f(32'h04030201)}, {1'b0, 64'hFFFF_0000_FFF9_000A});
    @(posedge clk);
    #1;
    first_flag = 1'b1;
    send_row(32'h04030201, fe0);
    for (int r = 1; r < 4; r++) send_row(32'h04030201, fe);
    wait_drain();
    chk("single_first_lat", 65'(t_first - fe0), 65'd5);
    chk("single_last_lat", 65'(t_last - fe0), 65'd8);
    chk("single_first_col", first_beat, {1'b0, {4{16'h000A}}});
    chk("single_last_col", last_beat, {1'b1, {4{16'hFFFF}}});
    chk("single_blk", {49'd0, blk_cnt}, 65'd1);

    // Input gap in the middle of a block.
    send_row(mk_row(90, 0), fe);
    send_row(mk_row(90, 1), fe);
    repeat (3) @(posedge clk);
    #1;
    send_row(mk_row(90, 2), fe);
    send_row(mk_row(90, 3), fe);
    wait_drain();
    chk("gap_blk", {49'd0, blk_cnt}, 65'd2);

    // Streaming eight blocks back to back.
    send_row(mk_row(0, 0), fe0);
    for (int n = 1; n < 32; n++) send_row(mk_row(n / 4, n % 4), fe);
    wait_drain();
    chk("stream_done_by_43", {64'd0, (t_last - fe0) <= 43}, 65'd1);
    chk("stream_blk", {49'd0, blk_cnt}, 65'd10);

    // Backpressure: two blocks fill, input stalls, output holds steady.
    bus.out_ready = 1'b0;
    for (int n = 0; n < 8; n++) send_row(mk_row(20 + n / 4, n % 4), fe);
    @(negedge clk);
    chk("bp_in_ready", {64'd0, bus.in_ready}, 65'd0);
    chk("bp_out_valid", {64'd0, bus.out_valid}, 65'd1);
    repeat (20) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain();
    chk("bp_blk", {49'd0, blk_cnt}, 65'd12);

    // Async reset after row 2 of the second block, while the first drains.
    for (int n = 0; n < 7; n++) send_row(mk_row(40 + n / 4, n % 4), fe);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    chk("rst_mid_in_ready", {64'd0, bus.in_ready}, 65'd1);
    flush_model();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    first_flag = 1'b1;
    send_row(mk_row(60, 0), fe0);
    for (int r = 1; r < 4; r++) send_row(mk_row(60, r), fe);
    wait_drain();
    chk("post_rst_lat", 65'(t_first - fe0), 65'd5);
    chk("post_rst_blk", {49'd0, blk_cnt}, 65'd1);

    // Block counter wrap.
    force dut.r_blk_cnt = 16'hFFFF;
    mdl_blk = 16'hFFFF;
    #1;
    release dut.r_blk_cnt;
    @(negedge clk);
    chk("wrap_preload", {49'd0, blk_cnt}, 65'h0FFFF);
    @(posedge clk);
    #1;
    for (int r = 0; r < 4; r++) send_row(mk_row(70, r), fe);
    wait_drain();
    chk("wrap_blk", {49'd0, blk_cnt}, 65'd0);

    chk("leftover_beats", 65'(exp_q.size()), 65'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
